argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 10, the number of class scores per result.
REQ-002 SHALL have parameter RES_W, default 32, the width of each class score.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port i_pre_valid, input, 1, upstream score vector valid (from top_conv_acc o_post_valid).
REQ-006 SHALL have port o_pre_ready, output, 1, block can accept a score vector.
REQ-007 SHALL have port i_res, input, RES_W x NUM_CLASS unpacked, class scores in signed two's complement.
REQ-008 SHALL have port o_post_valid, output, 1, classification result valid.
REQ-009 SHALL have port i_post_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port o_class, output, $clog2(NUM_CLASS), index of the winning class.
REQ-011 SHALL have port o_max_score, output, RES_W, score of the winning class.
REQ-012 SHALL have port o_frame_cnt, output, 16, count of results delivered (handshakes on the output side).

Function
REQ-013 SHALL implement an FSM with states IDLE, SCAN and DONE.
REQ-014 SHALL drive o_pre_ready=1 only in IDLE and o_post_valid=1 only in DONE; both are registered-state decodes.
REQ-015 SHALL, in IDLE on i_pre_valid&&o_pre_ready, register all NUM_CLASS scores, set best=i_res[0], idx=0, cnt=1, and enter SCAN.
REQ-016 SHALL, in SCAN, compare the stored score[cnt] against best each cycle, one comparison per cycle.
REQ-017 SHALL replace best/idx only when score[cnt] > best (strict, signed); on ties the lowest index wins.
REQ-018 SHALL increment cnt each SCAN cycle and enter DONE after the comparison at cnt==NUM_CLASS-1.
REQ-019 SHALL give a latency of NUM_CLASS cycles: input accept edge at cycle T, o_post_valid high from cycle T+NUM_CLASS (10 for the default).
REQ-020 SHALL hold o_class and o_max_score stable while o_post_valid=1 and i_post_ready=0.
REQ-021 SHALL, in DONE on i_post_ready=1, increment o_frame_cnt (wrapping 0xFFFF->0) and return to IDLE; o_pre_ready is high the following cycle.
REQ-022 SHALL ignore i_pre_valid and i_res outside IDLE; captured scores are not affected by input changes during SCAN or DONE.
REQ-023 SHALL accept i_post_ready asserted before o_post_valid without effect.
REQ-024 SHALL handle NUM_CLASS==1 by entering DONE directly from IDLE, with o_class=0.

Reset
REQ-025 SHALL, on i_rst low, asynchronously force state IDLE, o_post_valid=0, o_class=0, o_max_score=0, o_frame_cnt=0, cnt=0, and clear the score registers.
REQ-026 SHALL, on reset asserted mid-SCAN or mid-DONE, discard the in-flight result without producing a post handshake.
REQ-027 SHALL drive o_pre_ready=1 in the first cycle after reset deassertion.

Structure
REQ-028 SHALL take NUM_CLASS, RES_W, the class-index width and the FSM state enum from the shared package conv_acc_pkg.
REQ-029 SHALL place the signed strict-greater compare-and-select in one sub-module, argmax_cmp, which is combinational with inputs best, idx, cand, cand_idx and outputs new best and new idx.

Verification
REQ-030 SHALL cover scores {5,-3,9,2,9,0,1,1,-7,4} with i_post_ready=1 -> o_class=2, o_max_score=9, o_post_valid high exactly 10 cycles after accept, o_frame_cnt=1.
REQ-031 SHALL cover all scores = -1 (0xFFFFFFFF) -> o_class=0, o_max_score=0xFFFFFFFF.
REQ-032 SHALL cover scores 0x7FFFFFFF at index 9 and 0x80000000 elsewhere -> o_class=9; checks that the compare is signed.
REQ-033 SHALL cover i_post_ready held low for 20 cycles after valid -> outputs stable, o_pre_ready=0 throughout, and i_res changes ignored; after ready, o_pre_ready=1 on the next cycle.
REQ-034 SHALL cover i_rst pulsed low at SCAN cycle 4 -> no o_post_valid, o_frame_cnt=0, and the next vector {0,...,0,1 at index 7} yields o_class=7.
REQ-035 SHALL cover 65537 back-to-back frames -> o_frame_cnt=1 (wrap).

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared constants and types for the conv accumulator / classifier slice.
package conv_acc_pkg;

  localparam int unsigned NumClass = 10;
  localparam int unsigned ResW     = 32;

  // Index width that stays at least one bit when there is a single class.
  function automatic int unsigned class_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ClassW = class_w(NumClass);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare-and-select; ties keep the incumbent (lower index).
module argmax_cmp
  import conv_acc_pkg::*;
#(
  parameter int unsigned RES_W = ResW,
  parameter int unsigned IDX_W = ClassW
) (
  input  logic signed [RES_W-1:0] best_i,
  input  logic        [IDX_W-1:0] idx_i,
  input  logic signed [RES_W-1:0] cand_i,
  input  logic        [IDX_W-1:0] cand_idx_i,
  output logic signed [RES_W-1:0] best_o,
  output logic        [IDX_W-1:0] idx_o
);

  // Replace the running best only when the candidate is strictly larger.
  always_comb begin
    best_o = best_i;
    idx_o  = idx_i;
    if (cand_i > best_i) begin
      best_o = cand_i;
      idx_o  = cand_idx_i;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Captures a vector of class scores, scans it one entry per cycle and reports
// the index and value of the largest (signed) score.
module argmax_classifier
  import conv_acc_pkg::*;
#(
  parameter int unsigned NUM_CLASS = NumClass,
  parameter int unsigned RES_W     = ResW,
  localparam int unsigned IDX_W    = class_w(NUM_CLASS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pre_valid,
  output logic                    o_pre_ready,
  input  logic signed [RES_W-1:0] i_res [NUM_CLASS],
  output logic                    o_post_valid,
  input  logic                    i_post_ready,
  output logic [IDX_W-1:0]        o_class,
  output logic signed [RES_W-1:0] o_max_score,
  output logic [15:0]             o_frame_cnt
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASS - 1);

  state_e                  state_q;
  logic signed [RES_W-1:0] score_q [NUM_CLASS];
  logic [IDX_W-1:0]        cnt_q;
  logic signed [RES_W-1:0] best_q;
  logic [IDX_W-1:0]        idx_q;
  logic [15:0]             frame_q;

  logic signed [RES_W-1:0] cmp_best;
  logic [IDX_W-1:0]        cmp_idx;

  argmax_cmp #(
    .RES_W (RES_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .best_i     (best_q),
    .idx_i      (idx_q),
    .cand_i     (score_q[cnt_q]),
    .cand_idx_i (cnt_q),
    .best_o     (cmp_best),
    .idx_o      (cmp_idx)
  );

  // Result registers only change during SCAN, so they hold steady in DONE.
  assign o_pre_ready  = (state_q == StIdle);
  assign o_post_valid = (state_q == StDone);
  assign o_class      = idx_q;
  assign o_max_score  = best_q;
  assign o_frame_cnt  = frame_q;

  // Capture / scan / deliver state machine.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      score_q <= '{default: '0};
      cnt_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_pre_valid) begin
            score_q <= i_res;
            best_q  <= i_res[0];
            idx_q   <= '0;
            cnt_q   <= IDX_W'(1);
            // A single class needs no comparisons at all.
            state_q <= (NUM_CLASS == 1) ? StDone : StScan;
          end
        end
        StScan: begin
          best_q <= cmp_best;
          idx_q  <= cmp_idx;
          if (cnt_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        StDone: begin
          if (i_post_ready) begin
            frame_q <= frame_q + 16'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: default 10-class instance plus a
// single-class instance used for the frame counter wrap.
module tb_argmax_classifier;

  logic clk;
  logic rst;
  logic pre_valid;
  logic pre_ready;
  logic signed [31:0] res [10];
  logic post_valid;
  logic post_ready;
  logic [3:0] cls;
  logic signed [31:0] max_score;
  logic [15:0] frame_cnt;

  logic rst1;
  logic pre_valid1;
  logic pre_ready1;
  logic signed [31:0] res1 [1];
  logic post_valid1;
  logic post_ready1;
  logic [0:0] cls1;
  logic signed [31:0] max_score1;
  logic [15:0] frame_cnt1;

  int tests;
  int fails;
  int exp_frames;

  argmax_classifier #(
    .NUM_CLASS (10),
    .RES_W     (32)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pre_valid  (pre_valid),
    .o_pre_ready  (pre_ready),
    .i_res        (res),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .o_class      (cls),
    .o_max_score  (max_score),
    .o_frame_cnt  (frame_cnt)
  );

  argmax_classifier #(
    .NUM_CLASS (1),
    .RES_W     (32)
  ) dut1 (
    .i_clk        (clk),
    .i_rst        (rst1),
    .i_pre_valid  (pre_valid1),
    .o_pre_ready  (pre_ready1),
    .i_res        (res1),
    .o_post_valid (post_valid1),
    .i_post_ready (post_ready1),
    .o_class      (cls1),
    .o_max_score  (max_score1),
    .o_frame_cnt  (frame_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold pre_valid until the block is ready, then drop it after the accept edge.
  task automatic do_accept(output bit ok);
    ok = 1'b0;
    pre_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (pre_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_valid = 1'b0;
  endtask

  // Cycles counted with the accept edge as cycle 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!post_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    tests++; if (pre_ready !== 1'b1) begin fails++; $display("FAIL rst_pre_ready: got %b want 1", pre_ready); end
    tests++; if (post_valid !== 1'b0) begin fails++; $display("FAIL rst_post_valid: got %b want 0", post_valid); end
    tests++; if (cls !== 4'd0) begin fails++; $display("FAIL rst_class: got %0d want 0", cls); end
    tests++; if (max_score !== 32'sd0) begin fails++; $display("FAIL rst_score: got %0d want 0", max_score); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    post_ready = 1'b1;  // asserted long before valid
    res = '{32'sd5, -32'sd3, 32'sd9, 32'sd2, 32'sd9, 32'sd0, 32'sd1, 32'sd1, -32'sd7, 32'sd4};
    do_accept(ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_accept: got timeout want accept"); end
    wait_valid(lat);
    tests++; if (lat != 10 || post_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %0d valid=%b want 10 valid=1", lat, post_valid); end
    tests++; if (cls !== 4'd2) begin fails++; $display("FAIL basic_class: got %0d want 2", cls); end
    tests++; if (max_score !== 32'sd9) begin fails++; $display("FAIL basic_score: got %0d want 9", max_score); end
    @(posedge clk);
    #1;
    exp_frames++;
    tests++; if (frame_cnt !== 16'(exp_frames)) begin fails++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    tests++; if (pre_ready !== 1'b1 || post_valid !== 1'b0) begin fails++; $display("FAIL basic_return_idle: got ready=%b valid=%b want 1 0", pre_ready, post_valid); end
  endtask

  task automatic test_all_neg();
    bit ok;
    int lat;
    res = '{default: -32'sd1};
    do_accept(ok);
    wait_valid(lat);
    tests++; if (!ok || lat != 10) begin fails++; $display("FAIL neg_latency: got %0d ok=%b want 10", lat, ok); end
    tests++; if (cls !== 4'd0) begin fails++; $display("FAIL neg_class: got %0d want 0", cls); end
    tests++; if (max_score !== 32'hFFFF_FFFF) begin fails++; $display("FAIL neg_score: got %h want ffffffff", max_score); end
    @(posedge clk);
    #1;
    exp_frames++;
  endtask

  task automatic test_signed();
    bit ok;
    int lat;
    res = '{default: 32'sh8000_0000};
    res[9] = 32'sh7FFF_FFFF;
    do_accept(ok);
    wait_valid(lat);
    tests++; if (!ok || lat != 10) begin fails++; $display("FAIL signed_latency: got %0d ok=%b want 10", lat, ok); end
    tests++; if (cls !== 4'd9) begin fails++; $display("FAIL signed_class: got %0d want 9", cls); end
    tests++; if (max_score !== 32'sh7FFF_FFFF) begin fails++; $display("FAIL signed_score: got %h want 7fffffff", max_score); end
    @(posedge clk);
    #1;
    exp_frames++;
    tests++; if (frame_cnt !== 16'(exp_frames)) begin fails++; $display("FAIL signed_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    post_ready = 1'b0;
    res = '{32'sd3, 32'sd1, 32'sd4, 32'sd1, 32'sd5, 32'sd9, 32'sd2, 32'sd6, 32'sd5, 32'sd3};
    do_accept(ok);
    // Input churn during SCAN must not reach the captured scores.
    res = '{default: 32'sd100};
    pre_valid = 1'b1;
    wait_valid(lat);
    tests++; if (!ok || lat != 10) begin fails++; $display("FAIL stall_latency: got %0d ok=%b want 10", lat, ok); end
    tests++; if (cls !== 4'd5 || max_score !== 32'sd9) begin fails++; $display("FAIL stall_result: got %0d/%0d want 5/9", cls, max_score); end
    for (int i = 0; i < 20; i++) begin
      res[i % 10] = 32'(i * 37 + 200);
      @(posedge clk);
      #1;
      tests++;
      if (post_valid !== 1'b1 || pre_ready !== 1'b0 || cls !== 4'd5 || max_score !== 32'sd9) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%b c=%0d s=%0d want v=1 r=0 c=5 s=9",
                 i, post_valid, pre_ready, cls, max_score);
      end
    end
    pre_valid = 1'b0;
    post_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_frames++;
    tests++; if (pre_ready !== 1'b1 || post_valid !== 1'b0) begin fails++; $display("FAIL stall_release: got ready=%b valid=%b want 1 0", pre_ready, post_valid); end
    tests++; if (frame_cnt !== 16'(exp_frames)) begin fails++; $display("FAIL stall_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    bit seen;
    int lat;
    post_ready = 1'b1;
    res = '{default: 32'sd5};
    do_accept(ok);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    exp_frames = 0;
    tests++; if (post_valid !== 1'b0 || pre_ready !== 1'b1) begin fails++; $display("FAIL midrst_state: got valid=%b ready=%b want 0 1", post_valid, pre_ready); end
    tests++; if (frame_cnt !== 16'd0 || cls !== 4'd0 || max_score !== 32'sd0) begin fails++; $display("FAIL midrst_regs: got f=%0d c=%0d s=%0d want 0 0 0", frame_cnt, cls, max_score); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (post_valid) seen = 1'b1;
    end
    tests++; if (seen || frame_cnt !== 16'd0) begin fails++; $display("FAIL midrst_no_result: got seen=%b f=%0d want 0 0", seen, frame_cnt); end
    res = '{default: 32'sd0};
    res[7] = 32'sd1;
    do_accept(ok);
    wait_valid(lat);
    tests++; if (!ok || lat != 10) begin fails++; $display("FAIL midrst_latency: got %0d ok=%b want 10", lat, ok); end
    tests++; if (cls !== 4'd7 || max_score !== 32'sd1) begin fails++; $display("FAIL midrst_class: got %0d/%0d want 7/1", cls, max_score); end
    @(posedge clk);
    #1;
    exp_frames++;
    tests++; if (frame_cnt !== 16'(exp_frames)) begin fails++; $display("FAIL midrst_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back_wrap();
    int hs;
    int cyc;
    rst1 = 1'b1;
    #1;
    tests++; if (pre_ready1 !== 1'b1) begin fails++; $display("FAIL wrap_pre_ready: got %b want 1", pre_ready1); end
    res1[0] = -32'sd5;
    pre_valid1 = 1'b1;
    post_ready1 = 1'b1;
    @(posedge clk);
    #1;
    // One class goes straight from IDLE to DONE.
    tests++; if (post_valid1 !== 1'b1) begin fails++; $display("FAIL wrap_direct_done: got %b want 1", post_valid1); end
    tests++; if (cls1 !== 1'b0 || max_score1 !== -32'sd5) begin fails++; $display("FAIL wrap_result: got %0d/%0d want 0/-5", cls1, max_score1); end
    hs = 0;
    cyc = 0;
    while (hs < 65537 && cyc < 300000) begin
      if (post_valid1) hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    pre_valid1 = 1'b0;
    tests++; if (hs != 65537) begin fails++; $display("FAIL wrap_handshakes: got %0d want 65537", hs); end
    tests++; if (frame_cnt1 !== 16'd1) begin fails++; $display("FAIL wrap_frame_cnt: got %0d want 1", frame_cnt1); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_frames = 0;
    rst = 1'b0;
    pre_valid = 1'b0;
    post_ready = 1'b0;
    res = '{default: 32'sd0};
    rst1 = 1'b0;
    pre_valid1 = 1'b0;
    post_ready1 = 1'b0;
    res1 = '{default: 32'sd0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_all_neg();
    test_signed();
    test_stall();
    test_reset_mid_scan();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
